// File: rtl/manhattan_seqgen_pkg.sv
// Shared state encoding and default pattern for the serial sequence generator.
package manhattan_seqgen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [4:0] PAT_11010 = 5'b11010;

endpackage

// File: rtl/manhattan_piso_shifter.sv
// Parallel-in serial-out register; MSB is the serial bit, zeros fill from the LSB end.
module manhattan_piso_shifter #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [PAT_W-1:0] parallel_i,
  output logic             serial_o
);

  logic [PAT_W-1:0] shreg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (clear_i) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= parallel_i;
    end else if (shift_en_i) begin
      shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign serial_o = shreg_q[PAT_W-1];

endmodule

// File: rtl/manhattan_sequence_generator.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB-first with an idle gap
// between repetitions, then pulses done.
module manhattan_sequence_generator
  import manhattan_seqgen_pkg::*;
#(
  parameter int unsigned      PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_11010),
  parameter int unsigned      CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             use_param,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_count,
  input  logic [CNT_W-1:0] gap_cycles,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BCNT_W = $clog2(PAT_W + 1);

  state_e             state_q;
  logic [PAT_W-1:0]   pat_q;
  logic [BCNT_W-1:0]  bits_left_q;
  logic [CNT_W-1:0]   rep_left_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   gap_cnt_q;
  logic               bit_valid_q;
  logic               busy_q;
  logic               done_q;

  logic               start_ok_c;
  logic               last_bit_c;
  logic               more_reps_c;
  logic               gap_end_c;
  logic               load_c;
  logic               shift_c;
  logic               clear_c;
  logic [PAT_W-1:0]   sel_pat_c;
  logic [PAT_W-1:0]   load_pat_c;

  // Shifter control must act on the same edge as the state transition.
  always_comb begin
    start_ok_c  = (state_q == S_IDLE) && start && !abort;
    last_bit_c  = (state_q == S_SHIFT) && (bits_left_q == '0);
    more_reps_c = rep_left_q > CNT_W'(1);
    gap_end_c   = (state_q == S_GAP) && (gap_cnt_q <= CNT_W'(1));
    sel_pat_c   = use_param ? PATTERN : pattern_in;
    load_pat_c  = start_ok_c ? sel_pat_c : pat_q;
    clear_c     = abort && (state_q != S_IDLE);
    load_c      = start_ok_c ||
                  (!abort && ((last_bit_c && more_reps_c && (gap_q == '0)) || gap_end_c));
    shift_c     = !abort && (state_q == S_SHIFT) && !load_c;
  end

  manhattan_piso_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear_c),
    .load_i     (load_c),
    .shift_en_i (shift_c),
    .parallel_i (load_pat_c),
    .serial_o   (sequence_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      bits_left_q <= '0;
      rep_left_q  <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_c) begin
      state_q     <= S_IDLE;
      bits_left_q <= '0;
      rep_left_q  <= '0;
      gap_cnt_q   <= '0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok_c) begin
            pat_q       <= sel_pat_c;
            rep_left_q  <= (repeat_count == '0) ? CNT_W'(1) : repeat_count;
            gap_q       <= gap_cycles;
            bits_left_q <= BCNT_W'(PAT_W - 1);
            state_q     <= S_SHIFT;
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bits_left_q != '0) begin
            bits_left_q <= bits_left_q - BCNT_W'(1);
          end else begin
            if (rep_left_q != '0) rep_left_q <= rep_left_q - CNT_W'(1);
            if (more_reps_c) begin
              if (gap_q == '0) begin
                bits_left_q <= BCNT_W'(PAT_W - 1);
              end else begin
                state_q     <= S_GAP;
                gap_cnt_q   <= gap_q;
                bit_valid_q <= 1'b0;
              end
            end else begin
              state_q     <= S_DONE;
              bit_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q > CNT_W'(1)) begin
            gap_cnt_q <= gap_cnt_q - CNT_W'(1);
          end else begin
            gap_cnt_q   <= '0;
            bits_left_q <= BCNT_W'(PAT_W - 1);
            state_q     <= S_SHIFT;
            bit_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_manhattan_sequence_generator.sv
// Scoreboard bench: stimulus pushes expected bits/done/busy lengths, a negedge monitor checks.
module tb_manhattan_sequence_generator;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic       use_param;
  logic [4:0] pattern_in;
  logic [3:0] repeat_count;
  logic [3:0] gap_cycles;
  logic       sequence_out;
  logic       bit_valid;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic is_done;
    logic val;
  } item_t;

  item_t exp_q[$];
  int    busy_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    busy_run = 0;

  manhattan_sequence_generator dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .use_param    (use_param),
    .pattern_in   (pattern_in),
    .repeat_count (repeat_count),
    .gap_cycles   (gap_cycles),
    .sequence_out (sequence_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void report_unexpected(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
  endfunction

  // Hand-supplied pattern, repeated reps times, then a done and the busy-run length.
  task automatic push_frame(input logic [4:0] pat, input int reps, input int busy_len);
    logic [4:0] p;
    item_t it;
    p = pat;
    for (int r = 0; r < reps; r++) begin
      for (int b = 4; b >= 0; b--) begin
        it.is_done = 1'b0;
        it.val     = p[b];
        exp_q.push_back(it);
      end
    end
    it.is_done = 1'b1;
    it.val     = 1'b0;
    exp_q.push_back(it);
    busy_q.push_back(busy_len);
  endtask

  task automatic push_bits(input logic [4:0] bits, input int n, input int busy_len);
    logic [4:0] p;
    item_t it;
    p = bits;
    for (int b = 4; b > 4 - n; b--) begin
      it.is_done = 1'b0;
      it.val     = p[b];
      exp_q.push_back(it);
    end
    busy_q.push_back(busy_len);
  endtask

  task automatic pulse_start(input logic up, input logic [4:0] pat, input logic [3:0] reps,
                             input logic [3:0] gap);
    @(posedge clock);
    #1;
    use_param    = up;
    pattern_in   = pat;
    repeat_count = reps;
    gap_cycles   = gap;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_seq"},   sequence_out, 0);
    check({tag, "_valid"}, bit_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
  endtask

  // Monitor: consumes one expected item per valid bit or done pulse.
  always @(negedge clock) begin
    item_t it;
    if (bit_valid) begin
      if (exp_q.size() == 0) begin
        report_unexpected("bit");
      end else begin
        it = exp_q.pop_front();
        check("bit_slot", int'(it.is_done), 0);
        check("seq_bit", sequence_out, int'(it.val));
      end
    end else if (busy) begin
      check("gap_seq_zero", sequence_out, 0);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        report_unexpected("done");
      end else begin
        it = exp_q.pop_front();
        check("done_slot", int'(it.is_done), 1);
        check("done_busy_low", busy, 0);
      end
    end
    if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      if (busy_q.size() == 0) report_unexpected("busy_run");
      else check("busy_len", busy_run, busy_q.pop_front());
      busy_run = 0;
    end
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    use_param    = 1'b1;
    pattern_in   = 5'b00000;
    repeat_count = 4'd1;
    gap_cycles   = 4'd0;
    #12;
    check_idle_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Built-in pattern, single repetition.
    push_frame(5'b11010, 1, 5);
    pulse_start(1'b1, 5'b00000, 4'd1, 4'd0);
    repeat (8) @(posedge clock);

    // Runtime pattern, two repetitions, gap of 3.
    push_frame(5'b10011, 2, 13);
    pulse_start(1'b0, 5'b10011, 4'd2, 4'd3);
    repeat (16) @(posedge clock);

    // repeat_count 0 behaves as a single repetition.
    push_frame(5'b11010, 1, 5);
    pulse_start(1'b1, 5'b01010, 4'd0, 4'd0);
    repeat (8) @(posedge clock);

    // Three back-to-back repetitions.
    push_frame(5'b11010, 3, 15);
    pulse_start(1'b1, 5'b00000, 4'd3, 4'd0);
    repeat (18) @(posedge clock);

    // Start re-pulsed mid-frame and during done; start held into the next idle cycle.
    push_frame(5'b11010, 1, 5);
    push_frame(5'b11010, 1, 5);
    @(posedge clock);
    #1;
    use_param = 1'b1; repeat_count = 4'd1; gap_cycles = 4'd0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1; use_param = 1'b0; pattern_in = 5'b00000; repeat_count = 4'd3; gap_cycles = 4'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("done_cycle", done, 1);
    start = 1'b1; use_param = 1'b1; repeat_count = 4'd1; gap_cycles = 4'd0;
    @(posedge clock);
    #1;
    check("no_start_in_done", busy, 0);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("restart_after_done", busy, 1);
    repeat (8) @(posedge clock);

    // Abort on the third bit of a two-repetition frame.
    push_bits(5'b11010, 3, 3);
    pulse_start(1'b1, 5'b00000, 4'd2, 4'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check_idle_outputs("abort");
    repeat (4) @(posedge clock);
    push_frame(5'b11010, 1, 5);
    pulse_start(1'b1, 5'b00000, 4'd1, 4'd0);
    repeat (8) @(posedge clock);

    // Reset asserted during the second gap cycle.
    push_bits(5'b10011, 5, 6);
    pulse_start(1'b0, 5'b10011, 4'd2, 4'd3);
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    push_frame(5'b10011, 2, 13);
    pulse_start(1'b0, 5'b10011, 4'd2, 4'd3);
    repeat (16) @(posedge clock);

    check("scoreboard_drained", exp_q.size(), 0);
    check("busy_runs_drained", busy_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/manhattan_sequence_generator.md
Name: manhattan_sequence_generator

Overview:
- Serial bit-stream transmitter: the stimulus end of the serial sequence-detection path.
- Loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repetitions, then pulses done.
- Drives the single-bit sequence_in of the team's sequence detectors. The default pattern is 11010.

Parameters:
- PAT_W, 5, pattern width in bits (2..16).
- PATTERN, 5'b11010, built-in pattern used when use_param=1.
- CNT_W, 4, width of the repeat_count and gap_cycles fields.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- start  in  1  request a frame; sampled only in IDLE.
- abort  in  1  synchronous cancel of a frame in progress.
- use_param  in  1  1 = send PATTERN; 0 = send pattern_in.
- pattern_in  in  PAT_W  runtime pattern; latched on accepted start.
- repeat_count  in  CNT_W  number of pattern repetitions; 0 is treated as 1. Latched on accepted start.
- gap_cycles  in  CNT_W  idle cycles between repetitions; 0 means back-to-back. Latched on accepted start.
- sequence_out  out  1  serial data, registered.
- bit_valid  out  1  high while sequence_out carries a pattern bit, registered.
- busy  out  1  high in SHIFT and GAP, registered.
- done  out  1  one-cycle pulse after the last bit of the last repetition, registered.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; sequence_out=0, bit_valid=0, busy=0, done=0.
  - Shift register, bit counter, repeat counter and gap counter all cleared.
  - Reset in the middle of a frame drops the frame with no done pulse. First accepted start after reset deasserts behaves normally.
- States: IDLE, SHIFT, GAP, DONE. Encoding 2 bits: 00, 01, 10, 11. Any other encoding goes to IDLE.
- IDLE:
  - Outputs are 0.
  - On an edge with start=1 and abort=0:
    - Latch the pattern, reps=max(repeat_count,1) and gap=gap_cycles.
    - Go to SHIFT.
    - On that same edge drive sequence_out=pattern[PAT_W-1], bit_valid=1, busy=1.
    - Latency from the start-sampling edge to the first valid bit is therefore 0 cycles: the bit is visible after that edge.
- SHIFT:
  - Each edge presents the next lower bit of the pattern.
  - After PAT_W valid cycles, decrement the repeat counter.
  - If repetitions remain and gap>0: go to GAP. sequence_out=0, bit_valid=0, busy=1 for exactly gap cycles.
  - If repetitions remain and gap=0: the next repetition's MSB follows on the very next cycle with no bubble.
  - If none remain: go to DONE. sequence_out=0, bit_valid=0, busy=0.
- GAP:
  - Counts down gap cycles.
  - On the final gap cycle's edge, reload the shift register from the latched pattern and present its MSB (state SHIFT).
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - A start during DONE is ignored. It is first sampled in the following IDLE cycle.
- Frame length: busy is high for reps*PAT_W + (reps-1)*gap cycles.
- start while busy or in DONE: ignored. No queuing.
- Latched values are held for the whole frame. pattern_in, repeat_count and gap_cycles changing mid-frame have no effect.
- abort=1 in SHIFT, GAP or DONE: next edge goes to IDLE with all outputs 0 and no done pulse.
- abort together with start in IDLE: abort wins and nothing starts.
- Counter widths:
  - Bit counter: ceil(log2(PAT_W+1)) bits.
  - Repeat and gap counters: CNT_W bits each.
  - Counters never wrap: a counter at 0 is never decremented.

Decomposition:
- Package manhattan_seqgen_pkg holds:
  - state encoding constants S_IDLE, S_SHIFT, S_GAP, S_DONE;
  - the default pattern constant PAT_11010 = 5'b11010.
- One natural sub-module, manhattan_piso_shifter. It is a PAT_W-bit parallel-in serial-out register with load, shift_en and a serial_out MSB.
- The top level holds the FSM and the counters.

Test Plan:
- use_param=1, repeat_count=1, gap=0, start pulse:
  - sequence_out 1,1,0,1,0 with bit_valid=1 for 5 cycles;
  - done high on cycle 6; busy high for 5 cycles.
- use_param=0, pattern_in=5'b10011, repeat_count=2, gap=3:
  - 1,0,0,1,1, then 3 cycles of bit_valid=0 and out=0, then 1,0,0,1,1;
  - busy high for 13 cycles, done on cycle 14.
- repeat_count=0, gap=0, PATTERN:
  - exactly one repetition (5 bits), done once.
- repeat_count=3, gap=0, PATTERN:
  - 15 contiguous valid bits 11010 11010 11010 with no bubble, then done.
- start re-pulsed in mid-frame and in the DONE cycle:
  - ignored, output unchanged;
  - a start in the following IDLE cycle launches a new frame.
- abort on the 3rd bit, and separately reset asserted on the 2nd gap cycle:
  - next edge: all outputs 0, state IDLE, no done pulse;
  - a subsequent start yields the full correct frame.
